// File: rtl/fifo_rd_ctrl.sv
// Async FIFO read-side controller: write-pointer synchroniser, RAM read addressing and a
// first-word-fall-through output stage with one skid word. Optional rd_count port: FIFO_RD_COUNT_EN.
module fifo_rd_ctrl #(
    parameter int P_DEPTH       = 1024,
    parameter int P_WIDTH       = 8,
    parameter int P_SYNC_STAGES = 2,
    localparam int ADDR_BITS    = $clog2(P_DEPTH)
) (
    input  logic                 rd_clk,
    input  logic                 rd_rst,
    input  logic [ADDR_BITS:0]   wr_ptr_gray,
    output logic [ADDR_BITS:0]   rd_ptr_gray,
    output logic [ADDR_BITS-1:0] bram_rd_addr,
    input  logic [P_WIDTH-1:0]   bram_rd_data,
    output logic [P_WIDTH-1:0]   m_data,
    output logic                 m_valid,
    input  logic                 m_ready,
`ifdef FIFO_RD_COUNT_EN
    output logic [ADDR_BITS:0]   rd_count,
`endif
    output logic                 empty
);

    localparam int PW = ADDR_BITS + 1;

    function automatic logic [ADDR_BITS:0] gray2bin(input logic [ADDR_BITS:0] g);
        logic [ADDR_BITS:0] b;
        b[ADDR_BITS] = g[ADDR_BITS];
        for (int i = ADDR_BITS - 1; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [ADDR_BITS:0] bin2gray(input logic [ADDR_BITS:0] b);
        return b ^ (b >> 1);
    endfunction

    logic [ADDR_BITS:0] sync_q [P_SYNC_STAGES];
    logic [ADDR_BITS:0] wr_bin_s;
    logic [ADDR_BITS:0] rd_bin;
    logic [ADDR_BITS:0] avail;
    logic [ADDR_BITS:0] rd_ptr_gray_q;

    logic               inflight;
    logic               out_vld;
    logic [P_WIDTH-1:0] out_data;
    logic               skid_vld;
    logic [P_WIDTH-1:0] skid_data;

    logic [1:0]         occ;
    logic [2:0]         load;
    logic               pop;
    logic               fetch;

    // Stage boundary: wr_clk-domain gray pointer into rd_clk domain.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            for (int i = 0; i < P_SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
        end else begin
            sync_q[0] <= wr_ptr_gray;
            for (int i = 1; i < P_SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign wr_bin_s = gray2bin(sync_q[P_SYNC_STAGES-1]);
    assign avail    = wr_bin_s - rd_bin;

    // A fetch is allowed only if the word it brings back will find a free slot next edge.
    assign occ   = {1'b0, out_vld} + {1'b0, skid_vld};
    assign pop   = out_vld & m_ready;
    assign load  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fetch = (avail != '0) && (load < 3'd2);

    // Stage boundary: fetch edge -- address issued to RAM, pointer advances.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_bin        <= '0;
            rd_ptr_gray_q <= '0;
            inflight      <= 1'b0;
        end else begin
            inflight      <= fetch;
            rd_ptr_gray_q <= bin2gray(rd_bin);
            if (fetch) begin
                rd_bin <= rd_bin + PW'(1);
            end
        end
    end

    // Stage boundary: capture edge -- RAM data lands in the output register or the skid.
    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            out_vld   <= 1'b0;
            out_data  <= '0;
            skid_vld  <= 1'b0;
            skid_data <= '0;
        end else if (pop) begin
            if (skid_vld) begin
                out_data <= skid_data;
                skid_vld <= inflight;
                if (inflight) begin
                    skid_data <= bram_rd_data;
                end
            end else begin
                out_vld <= inflight;
                if (inflight) begin
                    out_data <= bram_rd_data;
                end
            end
        end else if (inflight) begin
            if (!out_vld) begin
                out_vld  <= 1'b1;
                out_data <= bram_rd_data;
            end else begin
                skid_vld  <= 1'b1;
                skid_data <= bram_rd_data;
            end
        end
    end

`ifdef FIFO_RD_COUNT_EN
    logic [ADDR_BITS:0] rd_count_q;

    always_ff @(posedge rd_clk) begin
        if (rd_rst) begin
            rd_count_q <= '0;
        end else begin
            rd_count_q <= avail + PW'(inflight) + PW'(occ);
        end
    end

    assign rd_count = rd_count_q;
`endif

    assign bram_rd_addr = rd_bin[ADDR_BITS-1:0];
    assign rd_ptr_gray  = rd_ptr_gray_q;
    assign m_data       = out_data;
    assign m_valid      = out_vld;
    assign empty        = (avail == '0) && !inflight && (occ == 2'd0);

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl (P_DEPTH=16): behavioural RAM and write side, queue scoreboard.
module tb_fifo_rd_ctrl;

    logic       rd_clk = 1'b0;
    logic       rd_rst = 1'b1;
    logic [4:0] wr_ptr_gray = '0;
    logic [4:0] rd_ptr_gray;
    logic [3:0] bram_rd_addr;
    logic [7:0] bram_rd_data;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic       empty;
`ifdef FIFO_RD_COUNT_EN
    logic [4:0] rd_count;
`endif

    fifo_rd_ctrl #(.P_DEPTH(16), .P_WIDTH(8), .P_SYNC_STAGES(2)) dut (
        .rd_clk      (rd_clk),
        .rd_rst      (rd_rst),
        .wr_ptr_gray (wr_ptr_gray),
        .rd_ptr_gray (rd_ptr_gray),
        .bram_rd_addr(bram_rd_addr),
        .bram_rd_data(bram_rd_data),
        .m_data      (m_data),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
`ifdef FIFO_RD_COUNT_EN
        .rd_count    (rd_count),
`endif
        .empty       (empty)
    );

    always #5 rd_clk = ~rd_clk;

    logic [7:0] mem [16];
    always @(posedge rd_clk) bram_rd_data <= mem[bram_rd_addr];

    int         n_cmp = 0;
    int         n_err = 0;
    int         wr_cnt = 0;
    int         popped = 0;
    logic [7:0] sb [$];
    logic [4:0] prev_gray;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic write_word(input logic [7:0] v);
        mem[wr_cnt % 16] = v;
        sb.push_back(v);
        wr_cnt++;
    endtask

    task automatic publish();
        wr_ptr_gray = to_gray(5'(wr_cnt));
    endtask

    // Called at a falling edge; a pop scheduled for the coming rising edge is scored here.
    task automatic step(input logic r);
        logic [7:0] e;
        logic       in_rst;
        m_ready = r;
        in_rst  = rd_rst;
        if (m_valid === 1'b1 && r) begin
            n_cmp++;
            assert (sb.size() != 0) else begin
                n_err++;
                $error("FAIL extra_word: observed %0h expected none", m_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("pop_data", 32'(m_data), 32'(e));
                popped++;
            end
        end
        prev_gray = rd_ptr_gray;
        @(posedge rd_clk);
        @(negedge rd_clk);
        if (!in_rst) check("gray_step", 32'($countones(rd_ptr_gray ^ prev_gray) > 1), 32'(0));
    endtask

    task automatic do_reset();
        rd_rst = 1'b1;
        wr_cnt = 0;
        popped = 0;
        sb.delete();
        publish();
        step(1'b0);
        step(1'b0);
        rd_rst = 1'b0;
    endtask

    task automatic drain(input int budget, input bit alt);
        int k = 0;
        while ((sb.size() != 0 || empty !== 1'b1) && k < budget) begin
            step(alt ? (k % 2 == 0) : 1'b1);
            k++;
        end
        check("drain_sb", 32'(sb.size()), 32'(0));
        check("drain_empty", 32'(empty), 32'(1));
        check("drain_valid", 32'(m_valid), 32'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int k;
        int grp;
        int free;
        int iter;
        bit first;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        @(negedge rd_clk);

        // Reset state
        do_reset();
        check("rst_valid", 32'(m_valid), 32'(0));
        check("rst_empty", 32'(empty), 32'(1));
        check("rst_gray", 32'(rd_ptr_gray), 32'(0));
        check("rst_addr", 32'(bram_rd_addr), 32'(0));
        check("rst_data", 32'(m_data), 32'(0));
`ifdef FIFO_RD_COUNT_EN
        check("rst_count", 32'(rd_count), 32'(0));
`endif

        // Single word with edge-exact latency
        write_word(8'hA5);
        publish();
        step(1'b0);
        check("sw_e0_valid", 32'(m_valid), 32'(0));
        step(1'b0);
        check("sw_e1_valid", 32'(m_valid), 32'(0));
        check("sw_e1_empty", 32'(empty), 32'(0));
        check("sw_e1_addr", 32'(bram_rd_addr), 32'(0));
        step(1'b0);
        check("sw_e2_addr", 32'(bram_rd_addr), 32'(1));
        check("sw_e2_gray", 32'(rd_ptr_gray), 32'(0));
        check("sw_e2_valid", 32'(m_valid), 32'(0));
        step(1'b0);
        check("sw_e3_valid", 32'(m_valid), 32'(1));
        check("sw_e3_data", 32'(m_data), 32'(8'hA5));
        check("sw_e3_gray", 32'(rd_ptr_gray), 32'(1));
        check("sw_e3_empty", 32'(empty), 32'(0));
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            check("sw_hold_valid", 32'(m_valid), 32'(1));
            check("sw_hold_data", 32'(m_data), 32'(8'hA5));
        end
`ifdef FIFO_RD_COUNT_EN
        check("sw_count", 32'(rd_count), 32'(1));
`endif
        step(1'b1);
        check("sw_after_valid", 32'(m_valid), 32'(0));
        check("sw_after_empty", 32'(empty), 32'(1));

        // Burst at full throughput
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
        publish();
        k = 0;
        while (m_valid !== 1'b1 && k < 10) begin
            step(1'b1);
            k++;
        end
        check("burst_latency", 32'(k), 32'(4));
        for (int i = 0; i < 8; i++) begin
            check("burst_beat_valid", 32'(m_valid), 32'(1));
            step(1'b1);
        end
        check("burst_end_valid", 32'(m_valid), 32'(0));
        check("burst_end_empty", 32'(empty), 32'(1));
        check("burst_popped", 32'(popped), 32'(8));

        // Backpressure 1,0,1,0...
        do_reset();
        for (int i = 0; i < 8; i++) write_word(8'(8'h10 + i));
        publish();
        drain(80, 1'b1);
        check("bp_popped", 32'(popped), 32'(8));
        check("bp_addr", 32'(bram_rd_addr), 32'(8));

        // Wrap: 40 words, first group fills the FIFO completely
        do_reset();
        first = 1'b1;
        iter  = 0;
        while (wr_cnt < 40 && iter < 400) begin
            iter++;
            free = 16 - (wr_cnt - popped);
            grp  = first ? 16 : int'($urandom_range(1, 16));
            if (grp > free) grp = free;
            if (grp > 40 - wr_cnt) grp = 40 - wr_cnt;
            for (int i = 0; i < grp; i++) write_word(8'(wr_cnt * 7 + 3));
            publish();
            if (first) begin
                repeat (8) step(1'b0);
                check("full_addr", 32'(bram_rd_addr), 32'(2));
                check("full_valid", 32'(m_valid), 32'(1));
                check("full_data", 32'(m_data), 32'(8'h03));
                check("full_empty", 32'(empty), 32'(0));
`ifdef FIFO_RD_COUNT_EN
                check("full_count", 32'(rd_count), 32'(16));
`endif
                first = 1'b0;
            end
            repeat (6) step(1'($urandom_range(0, 1)));
        end
        check("wrap_written", 32'(wr_cnt), 32'(40));
        drain(300, 1'b0);
        check("wrap_popped", 32'(popped), 32'(40));
        check("wrap_gray", 32'(rd_ptr_gray), 32'(to_gray(5'd8)));

        // Reset mid-stream with held and in-flight words
        do_reset();
        for (int i = 0; i < 5; i++) write_word(8'(8'hC0 + i));
        publish();
        repeat (8) step(1'b0);
        step(1'b1);
        rd_rst = 1'b1;
        wr_cnt = 0;
        popped = 0;
        sb.delete();
        publish();
        step(1'b0);
        rd_rst = 1'b0;
        check("mrst_valid", 32'(m_valid), 32'(0));
        check("mrst_empty", 32'(empty), 32'(1));
        check("mrst_gray", 32'(rd_ptr_gray), 32'(0));
        check("mrst_addr", 32'(bram_rd_addr), 32'(0));
        check("mrst_data", 32'(m_data), 32'(0));
        for (int i = 0; i < 6; i++) begin
            step(1'b1);
            check("mrst_no_stale", 32'(m_valid), 32'(0));
        end
        write_word(8'h5A);
        publish();
        drain(20, 1'b0);
        check("mrst_new_word", 32'(popped), 32'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
